// File: rtl/button_bank_repeat.sv
// Multi-channel button front end: 2-FF sync, counter debounce, press/release pulses,
// hold-to-repeat and global block. Define BTN_ONEHOT_EN to arbitrate press/repeat to the lowest channel.
module button_bank_repeat #(
    parameter int N_CH            = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            block,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_mask,
    output logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [N_CH-1:0]  sync_p0, sync_p1;
    logic [N_CH-1:0]  press_q, release_q, rpt_q;
    logic [CNT_W-1:0] db_cnt  [N_CH];
    logic [CNT_W-1:0] rpt_tmr [N_CH];
    rpt_state_t       rpt_state [N_CH];

    logic [N_CH-1:0]  press_gated, rpt_gated, rpt_qual;
    logic [N_CH-1:0]  press_ev, rpt_ev;

    // Stage p0/p1: synchroniser, then debounce on the p1 level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            btn_level <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            for (int i = 0; i < N_CH; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                if (sync_p1[i] != btn_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_level[i] <= sync_p1[i];
                        db_cnt[i]    <= '0;
                        press_q[i]   <= sync_p1[i];
                        release_q[i] <= ~sync_p1[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Block masks events in the cycle they would appear, so they are dropped rather than deferred
    assign press_gated = press_q & ~{N_CH{block}};
    assign btn_release = release_q & ~{N_CH{block}};
    assign rpt_qual    = btn_level & repeat_mask & ~{N_CH{block}};
    assign rpt_gated   = rpt_q & rpt_qual;

`ifdef BTN_ONEHOT_EN
    assign press_ev = press_gated & (~press_gated + N_CH'(1));
    assign rpt_ev   = rpt_gated & (~rpt_gated + N_CH'(1));
`else
    assign press_ev = press_gated;
    assign rpt_ev   = rpt_gated;
`endif

    assign btn_raw    = sync_p1;
    assign btn_press  = press_ev;
    assign btn_repeat = rpt_ev;

    // Repeat FSM: rpt_q is set one cycle ahead of the pulse; the timer counts cycles since the last event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rpt_state[i] <= IDLE;
                rpt_tmr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                rpt_q[i] <= 1'b0;
                if (!rpt_qual[i]) begin
                    rpt_state[i] <= IDLE;
                    rpt_tmr[i]   <= '0;
                end else begin
                    case (rpt_state[i])
                        IDLE: begin
                            if (press_ev[i]) begin
                                if (REPEAT_DELAY == 1) begin
                                    rpt_q[i]     <= 1'b1;
                                    rpt_state[i] <= RPT;
                                    rpt_tmr[i]   <= '0;
                                end else begin
                                    rpt_state[i] <= DELAY;
                                    rpt_tmr[i]   <= CNT_W'(1);
                                end
                            end
                        end
                        DELAY: begin
                            if (rpt_tmr[i] == DELAY_LAST) begin
                                rpt_q[i]     <= 1'b1;
                                rpt_state[i] <= RPT;
                                rpt_tmr[i]   <= '0;
                            end else begin
                                rpt_tmr[i] <= rpt_tmr[i] + CNT_W'(1);
                            end
                        end
                        RPT: begin
                            if (rpt_tmr[i] == RATE_LAST) begin
                                rpt_q[i]   <= 1'b1;
                                rpt_tmr[i] <= '0;
                            end else begin
                                rpt_tmr[i] <= rpt_tmr[i] + CNT_W'(1);
                            end
                        end
                        default: begin
                            rpt_state[i] <= IDLE;
                            rpt_tmr[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_button_bank_repeat.sv
// Scoreboard bench for button_bank_repeat: directed scenarios plus random stimulus,
// checked every cycle against a windowed reference model.
module tb_button_bank_repeat;

    localparam int N_CH  = 4;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RR    = 3;
    localparam int CNT_W = 8;
    localparam int MAXC  = 4096;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            block = 1'b0;
    logic [N_CH-1:0] btn_in = '0;
    logic [N_CH-1:0] repeat_mask = '0;
    logic [N_CH-1:0] btn_raw, btn_level, btn_press, btn_release, btn_repeat;

    always #5 clk = ~clk;

    button_bank_repeat #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .block(block), .btn_in(btn_in), .repeat_mask(repeat_mask),
        .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] raw, lvl, press, rel, rpt;
    } exp_t;

    exp_t            sb_q[$];
    logic [N_CH-1:0] samp  [MAXC];
    logic [N_CH-1:0] lvl_h [MAXC];
    bit              active [N_CH];
    int              start  [N_CH];

    int cyc = 0, compared = 0, mismatched = 0, scen_base = 0;
    int press_cnt[N_CH], first_press[N_CH], last_press[N_CH];
    int rel_cnt[N_CH], first_rel[N_CH];
    int rpt_cnt[N_CH], first_rpt[N_CH], last_rpt[N_CH];

    function automatic logic [N_CH-1:0] lowest_only(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    // Level flips once the synchronised input has shown the opposite value for DB consecutive cycles;
    // repeats fire RD cycles after a qualifying press, then every RR cycles, while the hold stays qualified.
    task automatic model_cycle(input int t);
        exp_t            e;
        logic [N_CH-1:0] prev, tog, qual;
        e.cyc = t;
        e.raw = '0; e.lvl = '0; e.press = '0; e.rel = '0; e.rpt = '0;
        if (reset) begin
            for (int c = 0; c <= t; c++) samp[c] = '0;
            lvl_h[t] = '0;
            for (int i = 0; i < N_CH; i++) active[i] = 1'b0;
        end else begin
            samp[t] = btn_in;
            e.raw   = (t >= 2) ? samp[t-2] : '0;
            prev    = (t >= 1) ? lvl_h[t-1] : '0;
            for (int i = 0; i < N_CH; i++) begin
                tog[i] = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    int   c;
                    logic v;
                    c = t - j - 2;
                    v = (c >= 0) ? samp[c][i] : 1'b0;
                    if (v == prev[i]) tog[i] = 1'b0;
                end
            end
            e.lvl    = prev ^ tog;
            lvl_h[t] = e.lvl;
            e.press  = tog & e.lvl & ~{N_CH{block}};
            e.rel    = tog & ~e.lvl & ~{N_CH{block}};
`ifdef BTN_ONEHOT_EN
            e.press  = lowest_only(e.press);
`endif
            qual = e.lvl & repeat_mask & ~{N_CH{block}};
            for (int i = 0; i < N_CH; i++) begin
                if (!qual[i]) begin
                    active[i] = 1'b0;
                end else begin
                    if (active[i]) begin
                        int k;
                        k = t - start[i];
                        e.rpt[i] = (k == RD) || (k > RD && ((k - RD) % RR) == 0);
                    end
                    if (e.press[i]) begin
                        active[i] = 1'b1;
                        start[i]  = t;
                    end
                end
            end
`ifdef BTN_ONEHOT_EN
            e.rpt = lowest_only(e.rpt);
`endif
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input logic [N_CH-1:0] got, input logic [N_CH-1:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, expv);
        end
    endtask

    task automatic spot(input string name, input int got, input int expv);
        compared++;
        if (got != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    exp_t mon_e;
    int   mon_rel;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("btn_raw",     mon_e.cyc, btn_raw,     mon_e.raw);
            chk("btn_level",   mon_e.cyc, btn_level,   mon_e.lvl);
            chk("btn_press",   mon_e.cyc, btn_press,   mon_e.press);
            chk("btn_release", mon_e.cyc, btn_release, mon_e.rel);
            chk("btn_repeat",  mon_e.cyc, btn_repeat,  mon_e.rpt);
            mon_rel = mon_e.cyc - scen_base;
            for (int i = 0; i < N_CH; i++) begin
                if (btn_press[i]) begin
                    press_cnt[i]++;
                    if (first_press[i] < 0) first_press[i] = mon_rel;
                    last_press[i] = mon_rel;
                end
                if (btn_release[i]) begin
                    rel_cnt[i]++;
                    if (first_rel[i] < 0) first_rel[i] = mon_rel;
                end
                if (btn_repeat[i]) begin
                    rpt_cnt[i]++;
                    if (first_rpt[i] < 0) first_rpt[i] = mon_rel;
                    last_rpt[i] = mon_rel;
                end
            end
        end
    end

    task automatic step(input bit r, input bit b, input logic [N_CH-1:0] m, input logic [N_CH-1:0] x);
        @(posedge clk);
        #1;
        reset       = r;
        block       = b;
        repeat_mask = m;
        btn_in      = x;
        model_cycle(cyc);
        cyc++;
    endtask

    task automatic scen_begin();
        scen_base = cyc;
        for (int i = 0; i < N_CH; i++) begin
            press_cnt[i] = 0; first_press[i] = -1; last_press[i] = -1;
            rel_cnt[i]   = 0; first_rel[i]   = -1;
            rpt_cnt[i]   = 0; first_rpt[i]   = -1; last_rpt[i]   = -1;
        end
    endtask

    task automatic scen_end();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N_CH-1:0] x;
        logic [N_CH-1:0] rx;
        logic [N_CH-1:0] rm;
        bit              rb;
        int              rate;

        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);

        // single press, no repeat
        scen_begin();
        for (int t = 0; t <= 44; t++) begin
            x = '0; x[0] = (t <= 29);
            step(1'b0, 1'b0, '0, x);
        end
        scen_end();
        spot("s1 press count", press_cnt[0], 1);
        spot("s1 press cycle", first_press[0], 6);
        spot("s1 release cycle", first_rel[0], 36);
        spot("s1 repeat count", rpt_cnt[0], 0);

        // bouncing input
        scen_begin();
        for (int t = 0; t <= 55; t++) begin
            x = '0; x[1] = (t < 20) ? (((t / 2) % 2) == 0) : (t < 40);
            step(1'b0, 1'b0, '0, x);
        end
        scen_end();
        spot("s2 press count", press_cnt[1], 1);
        spot("s2 press cycle", first_press[1], 26);
        spot("s2 release cycle", first_rel[1], 46);

        // hold-to-repeat
        scen_begin();
        for (int t = 0; t <= 45; t++) begin
            x = '0; x[2] = (t <= 29);
            step(1'b0, 1'b0, 4'b0100, x);
        end
        scen_end();
        spot("s3 press cycle", first_press[2], 6);
        spot("s3 repeat count", rpt_cnt[2], 7);
        spot("s3 first repeat", first_rpt[2], 16);
        spot("s3 last repeat", last_rpt[2], 34);
        spot("s3 release cycle", first_rel[2], 36);

        // block across the press, released later
        scen_begin();
        for (int t = 0; t <= 45; t++) begin
            x = '0; x[0] = (t <= 29);
            step(1'b0, (t < 15), 4'b0001, x);
        end
        scen_end();
        spot("s4 press count", press_cnt[0], 0);
        spot("s4 repeat count", rpt_cnt[0], 0);
        spot("s4 release cycle", first_rel[0], 36);

        // reset in the middle of a repeat sequence
        scen_begin();
        for (int t = 0; t <= 75; t++) begin
            x = '0; x[2] = (t <= 59);
            step((t == 20 || t == 21), 1'b0, 4'b0100, x);
        end
        scen_end();
        spot("s5 press count", press_cnt[2], 2);
        spot("s5 second press", last_press[2], 28);
        spot("s5 repeat count", rpt_cnt[2], 12);
        spot("s5 last repeat", last_rpt[2], 65);
        spot("s5 release cycle", first_rel[2], 66);

        // simultaneous presses on two channels
        scen_begin();
        for (int t = 0; t <= 30; t++) begin
            x = (t <= 15) ? 4'b1001 : 4'b0000;
            step(1'b0, 1'b0, '0, x);
        end
        scen_end();
        spot("s6 ch0 press cycle", first_press[0], 6);
`ifdef BTN_ONEHOT_EN
        spot("s6 ch3 press count", press_cnt[3], 0);
`else
        spot("s6 ch3 press cycle", first_press[3], 6);
`endif
        spot("s6 ch3 release cycle", first_rel[3], 22);

        // randomized traffic
        rx = '0; rm = '0; rb = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            rate = (((t / 200) % 2) == 1) ? 30 : 4;
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(rate - 1) == 0) rx[i] = ~rx[i];
            if ($urandom_range(99) == 0) rm = N_CH'($urandom);
            if (rb) begin
                if ($urandom_range(14) == 0) rb = 1'b0;
            end else begin
                if ($urandom_range(59) == 0) rb = 1'b1;
            end
            step(($urandom_range(599) == 0), rb, rm, rx);
        end

        for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(negedge clk);
        #1;
        spot("scoreboard drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_bank_repeat.md
Name: button_bank_repeat

Overview:
Parametrised multi-channel button front end for the board controller inputs. Per channel it provides a 2-FF synchroniser, a counter-based debouncer and press/release edge pulses. It adds a per-channel hold-to-repeat generator (auto-repeat) and a global block input. It replaces the fixed 12-channel debouncer bank, and its outputs feed the game FSM cursor/digit logic.

Parameters:
N_CH, 12, number of button channels
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1
REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse; must be >= 1
REPEAT_RATE, 5000000, cycles between subsequent repeat pulses; must be >= 1
CNT_W, 25, width of debounce and repeat timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
block  input  1  suppresses all event pulses while high
btn_in  input  N_CH  raw asynchronous button levels, active-high
repeat_mask  input  N_CH  per-channel auto-repeat enable
btn_raw  output  N_CH  synchronised raw levels (second sync flop), for LEDs
btn_level  output  N_CH  debounced level
btn_press  output  N_CH  1-cycle pulse on accepted 0->1
btn_release  output  N_CH  1-cycle pulse on accepted 1->0
btn_repeat  output  N_CH  1-cycle auto-repeat pulse

Behaviour:
- Reset (async, active-high): all flops, timers and outputs go to 0; all repeat FSMs go to IDLE. Effect is immediate, including mid-hold or mid-repeat.
- Sync: 2 flops per channel. btn_raw is the second flop.
- Debounce, per channel:
  - If btn_raw != btn_level, the counter increments. When the counter would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
  - Any cycle with btn_raw == btn_level clears the counter.
  - A clean input edge is reflected on btn_level exactly DEBOUNCE_CYCLES+2 clock edges later.
- Edges: btn_press / btn_release are registered and asserted in the same cycle btn_level first shows its new value, for exactly 1 cycle.
- Repeat FSM, per channel: IDLE, DELAY, RPT.
  - IDLE -> DELAY on an unblocked press with repeat_mask=1. Timer is 0 on the press cycle.
  - DELAY: btn_repeat pulses when the timer reaches REPEAT_DELAY (that many cycles after the press pulse); then go to RPT with the timer cleared.
  - RPT: btn_repeat pulses every REPEAT_RATE cycles.
  - Any state -> IDLE the cycle btn_level is 0, repeat_mask is 0 or block is 1. No repeat pulse is issued on that cycle.
- Block:
  - While block=1, btn_press, btn_release and btn_repeat are forced to 0. Sync, debounce and btn_level keep running.
  - Events occurring under block are dropped, not deferred.
  - A button held across block deassertion produces no press and no repeats until it is released and pressed again. Its release is emitted if block is low at that point.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle (unless the optional feature is enabled).
- btn_press and btn_release are never both high on one channel. btn_press and btn_repeat are never both high on one channel.

Optional Feature:
Macro BTN_ONEHOT_EN.
- Defined: btn_press and btn_repeat are each arbitrated to at most one bit per cycle. The lowest index wins; losing events are dropped. btn_release and btn_level are unaffected.
- Undefined: all channels report independently.

Test Plan:
Common parameters: N_CH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, mask=0 unless stated.
1. btn_in[0]=1 at cycle 0, held to cycle 29 -> btn_level[0] rises at 6; btn_press[0] is high only at 6; no btn_repeat; release fall at 30 -> btn_release[0] at 36.
2. btn_in[1] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one btn_press[1], four stable cycles after the bouncing ends; no glitch on btn_level[1].
3. repeat_mask[2]=1, btn_in[2] held from cycle 0 to 29 -> press at 6; btn_repeat[2] at 16, 19, 22, 25, 28, 31, 34; release at 36; no repeat after 34.
4. block=1 during the entire press of ch0 -> btn_level[0] still rises at 6 with no press. Deassert block at 15 while held -> no press or repeat. Release at 30 -> btn_release[0] at 36.
5. Assert reset at cycle 20 during the ch2 repeat of scenario 3, while the input stays held -> all outputs read 0 immediately. Deassert at 22 -> btn_press[2] 6 cycles later; repeats restart from that press.
6. ch0 and ch3 pressed in the same cycle -> with BTN_ONEHOT_EN only btn_press[0] pulses; without it, both bits pulse in the same cycle.
